// File: rtl/led_pwm_engine.sv
// rtl/led_pwm_engine.sv - per-channel PWM/dim/blink LED waveform generator.
// Define LED_SHADOW_EN to sample duty/group settings only at PWM period boundaries.
module led_pwm_engine #(
  parameter int PRESCALE = 1,
  parameter int NUM_CH   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sleep,
  input  logic [2*NUM_CH-1:0] ledout,
  input  logic [8*NUM_CH-1:0] duty,
  input  logic [7:0]          grp_pwm,
  input  logic [7:0]          grp_freq,
  input  logic                dmblnk,
  output logic [NUM_CH-1:0]   leds,
  output logic                period_start,
  output logic                blink_on
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       pre_cnt;
  logic [7:0]          pwm_cnt;
  logic [7:0]          blink_cnt;
  logic                load_pending;
  logic [8*NUM_CH-1:0] duty_sh;
  logic [7:0]          grp_pwm_sh;
  logic [7:0]          grp_freq_sh;
  logic                dmblnk_sh;

  logic                tick;
  logic                boundary;
  logic                shadow_load;
  logic [7:0]          thr;
  logic [NUM_CH-1:0]   leds_nxt;

  assign tick     = (pre_cnt == PW'(PRESCALE - 1));
  assign boundary = (tick && (pwm_cnt == 8'hFF)) || load_pending;

`ifdef LED_SHADOW_EN
  assign shadow_load = boundary;
`else
  assign shadow_load = 1'b1;
`endif

  assign thr = 8'(((17'(grp_freq_sh) + 17'd1) * 17'(grp_pwm_sh)) >> 8);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [7:0] d;
    logic [7:0] eff;
    assign d   = duty_sh[8*i +: 8];
    // mode 11 either scales duty by the group level or gates it with the blink phase
    assign eff = !ledout[2*i] ? d :
                 dmblnk_sh    ? (blink_on ? d : 8'd0) :
                 8'((17'(d) * (17'(grp_pwm_sh) + 17'd1)) >> 8);
    assign leds_nxt[i] = ledout[2*i+1] ? (pwm_cnt < eff) : ledout[2*i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      load_pending <= 1'b1;
      duty_sh      <= '0;
      grp_pwm_sh   <= '0;
      grp_freq_sh  <= '0;
      dmblnk_sh    <= 1'b0;
      leds         <= '0;
      period_start <= 1'b0;
      blink_on     <= 1'b0;
    end else if (sleep) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      load_pending <= 1'b1;
      leds         <= '0;
      period_start <= 1'b0;
      blink_on     <= 1'b0;
    end else begin
      leds         <= leds_nxt;
      blink_on     <= (blink_cnt < thr);
      period_start <= boundary;
      if (boundary) begin
        pre_cnt      <= '0;
        pwm_cnt      <= '0;
        load_pending <= 1'b0;
        // grp_freq is what the shadow takes on this same edge
        blink_cnt    <= (blink_cnt >= grp_freq) ? 8'd0 : blink_cnt + 8'd1;
      end else if (tick) begin
        pre_cnt <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
      if (shadow_load) begin
        duty_sh     <= duty;
        grp_pwm_sh  <= grp_pwm;
        grp_freq_sh <= grp_freq;
        dmblnk_sh   <= dmblnk;
      end
    end
  end
endmodule

// File: tb/tb_led_pwm_engine.sv
// tb/tb_led_pwm_engine.sv - randomized and directed bench for led_pwm_engine against a period-level model.
module tb_led_pwm_engine;
  localparam int P   = 1;
  localparam int N   = 4;
  localparam int PER = 256 * P;
`ifdef LED_SHADOW_EN
  localparam int MID_EXP = 64;
`else
  localparam int MID_EXP = 192;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sleep;
  logic [7:0]   ledout;
  logic [31:0]  duty;
  logic [7:0]   grp_pwm;
  logic [7:0]   grp_freq;
  logic         dmblnk;
  logic [3:0]   leds;
  logic         period_start;
  logic         blink_on;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: position within period in clk cycles plus captured settings
  int       pos, bc, gp, gf;
  int       dsh[N];
  bit       pend, db;
  bit [3:0] m_leds;
  bit       m_ps, m_bo;
  int       hi[N];
  int       ps_n, bo_n;

  always #5 clk = ~clk;

  led_pwm_engine #(.PRESCALE(P), .NUM_CH(N)) dut (
    .clk(clk), .reset(reset), .sleep(sleep), .ledout(ledout), .duty(duty),
    .grp_pwm(grp_pwm), .grp_freq(grp_freq), .dmblnk(dmblnk),
    .leds(leds), .period_start(period_start), .blink_on(blink_on)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0; bc = 0; gp = 0; gf = 0; db = 0; pend = 1;
    for (int i = 0; i < N; i++) dsh[i] = 0;
    m_leds = '0; m_ps = 0; m_bo = 0;
  endtask

  task automatic load_sh();
    for (int i = 0; i < N; i++) dsh[i] = int'(duty[8*i +: 8]);
    gp = int'(grp_pwm); gf = int'(grp_freq); db = dmblnk;
  endtask

  task automatic model_step();
    int lvl, eff, mode;
    bit [3:0] nl;
    bit bound;
    if (reset) begin model_reset(); return; end
    if (sleep) begin
      m_leds = '0; m_ps = 0; m_bo = 0; pos = 0; bc = 0; pend = 1;
      return;
    end
    lvl = pos / P;
    for (int i = 0; i < N; i++) begin
      mode = int'(ledout[2*i +: 2]);
      if (mode == 3) eff = db ? (m_bo ? dsh[i] : 0) : dsh[i] * (gp + 1) / 256;
      else           eff = dsh[i];
      nl[i] = (mode == 1) || (mode >= 2 && lvl < eff);
    end
    bound  = pend || (pos == PER - 1);
    m_bo   = (bc < (gf + 1) * gp / 256);
    m_leds = nl;
    m_ps   = bound;
    if (bound) begin
      pos = 0; pend = 0;
      bc = (bc >= int'(grp_freq)) ? 0 : bc + 1;
    end else begin
      pos++;
    end
`ifdef LED_SHADOW_EN
    if (bound) load_sh();
`else
    load_sh();
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("leds", leds, m_leds);
    check_eq("period_start", period_start, m_ps);
    check_eq("blink_on", blink_on, m_bo);
    for (int i = 0; i < N; i++) hi[i] += int'(leds[i]);
    ps_n += int'(period_start);
    bo_n += int'(blink_on);
  endtask

  task automatic acc_start();
    for (int i = 0; i < N; i++) hi[i] = int'(leds[i]);
    ps_n = int'(period_start);
    bo_n = int'(blink_on);
  endtask

  task automatic align();
    int k = 0;
    do begin cycle(); k++; end while (!m_ps && k < 2 * PER + 4);
    check_eq("align_period_start", period_start, 1);
  endtask

  task automatic measure(input int n);
    align();
    acc_start();
    repeat (n - 1) cycle();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; sleep = 0; ledout = '0; duty = '0;
    grp_pwm = '0; grp_freq = '0; dmblnk = 0;
    model_reset();
    repeat (3) cycle();
    check_eq("reset_leds", leds, 0);
    check_eq("reset_period_start", period_start, 0);
    check_eq("reset_blink_on", blink_on, 0);
    reset = 0;

    // single PWM channel
    ledout = 8'b00_00_00_10; duty = 32'h0000_0040;
    measure(PER);
    check_eq("t1_ch0_high", hi[0], 64);
    check_eq("t1_other_high", hi[1] + hi[2] + hi[3], 0);
    check_eq("t1_period_starts", ps_n, 1);

    // full on, duty 0 and duty 255
    ledout = 8'b10_10_01_10; duty = 32'hFF00_0040;
    align();
    measure(PER);
    check_eq("t2_ch1_on", hi[1], 256);
    check_eq("t2_ch2_zero", hi[2], 0);
    check_eq("t2_ch3_full", hi[3], 255);

    // group dim
    ledout = 8'b00_00_00_11; duty = 32'h80; dmblnk = 0; grp_pwm = 8'h7F;
    align(); measure(PER);
    check_eq("t3_dim_7f", hi[0], 64);
    grp_pwm = 8'hFF;
    align(); measure(PER);
    check_eq("t3_dim_ff", hi[0], 128);
    grp_pwm = 8'h00;
    align(); measure(PER);
    check_eq("t3_dim_00", hi[0], 0);

    // group blink
    duty = 32'hFF; dmblnk = 1; grp_freq = 8'd3; grp_pwm = 8'h80;
    align(); align();
    measure(4 * PER);
    check_eq("t4_blink_on_cycles", bo_n, 512);
    check_eq("t4_blink_led_high", hi[0], 510);
    check_eq("t4_period_starts", ps_n, 4);
    grp_pwm = 8'h00;
    align(); measure(PER);
    check_eq("t4_blink_off", bo_n, 0);

    // mid-period duty change
    ledout = 8'b00_00_00_10; dmblnk = 0; duty = 32'h40; grp_freq = 0;
    align(); align(); align();
    acc_start();
    repeat (16) cycle();
    duty = 32'hC0;
    repeat (PER - 17) cycle();
    check_eq("t5_change_period", hi[0], MID_EXP);
    measure(PER);
    check_eq("t5_next_period", hi[0], 192);

    // sleep mid-period
    duty = 32'h40;
    align(); align();
    repeat (20) cycle();
    check_eq("t6_pre_sleep_led", leds[0], 1);
    sleep = 1; duty = 32'h20;
    cycle();
    check_eq("t6_sleep_leds", leds, 0);
    check_eq("t6_sleep_ps", period_start, 0);
    check_eq("t6_sleep_bo", blink_on, 0);
    repeat (5) cycle();
    sleep = 0;
    cycle();
    check_eq("t6_wake_ps", period_start, 1);
    cycle(); acc_start();
    repeat (PER - 1) cycle();
    check_eq("t6_wake_duty", hi[0], 32);

    // reset mid-period
    align();
    repeat (30) cycle();
    check_eq("t6_pre_reset_led", leds[0], 1);
    #1 reset = 1;
    model_reset();
    #1;
    check_eq("t6_reset_leds", leds, 0);
    check_eq("t6_reset_ps", period_start, 0);
    check_eq("t6_reset_bo", blink_on, 0);
    repeat (2) cycle();
    reset = 0;
    cycle();
    check_eq("t6_release_ps", period_start, 1);
    cycle(); acc_start();
    repeat (PER - 1) cycle();
    check_eq("t6_release_duty", hi[0], 32);

    // randomized segments with occasional sleep and mid-run writes
    for (int seg = 0; seg < 20; seg++) begin
      ledout   = 8'($urandom);
      duty     = $urandom;
      grp_pwm  = 8'($urandom);
      grp_freq = 8'($urandom_range(0, 5));
      dmblnk   = 1'($urandom_range(0, 1));
      repeat ($urandom_range(256, 1500)) begin
        cycle();
        if ($urandom_range(0, 199) == 0) duty = $urandom;
        if ($urandom_range(0, 299) == 0) grp_pwm = 8'($urandom);
        if ($urandom_range(0, 299) == 0) ledout = 8'($urandom);
        sleep = ($urandom_range(0, 399) == 0) ? 1'b1 : (sleep && ($urandom_range(0, 3) != 0));
      end
      sleep = 0;
    end
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pwm_engine.md
Name: led_pwm_engine

Overview:
- Per-channel PWM/dim/blink generator for the 4 LED outputs; sits downstream of the LED register file and drives the `leds` pins.
- Consumes register-file levels: per-channel duty, LEDOUT mode, group PWM, group frequency, dim/blink select and sleep.
- Produces glitch-free registered LED waveforms.
- Duty and group settings are double-buffered at PWM period boundaries.

Parameters:
- PRESCALE, 1, clk cycles per PWM step (≥1); one PWM period = 256*PRESCALE clk cycles.
- NUM_CH, 4, number of LED channels.

Ports:
- clk  input  1  system clock (400 kHz oscillator domain).
- reset  input  1  asynchronous, active-high reset.
- sleep  input  1  MODE sleep bit; 1 = outputs off, counters held at 0.
- ledout  input  2*NUM_CH  per-channel mode, ch i at [2i+1:2i]: 00 off, 01 full on, 10 individual PWM, 11 individual PWM gated/scaled by group.
- duty  input  8*NUM_CH  per-channel duty, ch i at [8i+7:8i].
- grp_pwm  input  8  group duty (dim scale or blink duty).
- grp_freq  input  8  blink period minus 1, in PWM periods.
- dmblnk  input  1  0 = group dim, 1 = group blink.
- leds  output  NUM_CH  LED drive, active-high.
- period_start  output  1  one-cycle pulse at each PWM period start.
- blink_on  output  1  current blink gate state.

Behaviour:
- Reset (async): all outputs 0; pre_cnt, pwm_cnt, blink_cnt = 0; shadow registers = 0; load_pending = 1.
- Prescaler pre_cnt counts 0..PRESCALE-1. tick = (pre_cnt == PRESCALE-1). With PRESCALE=1, tick is every cycle.
- pwm_cnt (8 bit) increments on tick and wraps 255→0.
- Boundary event = (tick && pwm_cnt == 255) || load_pending. load_pending clears on the boundary edge.
- Shadow load on the boundary edge: duty_sh, grp_pwm_sh, grp_freq_sh, dmblnk_sh. ledout is not shadowed.
- period_start = 1 for exactly the cycle in which pwm_cnt==0 && pre_cnt==0 following a boundary; registered.
- Effective duty per channel, computed from shadows:
  - mode 10: eff = duty_sh.
  - mode 11, dim (dmblnk_sh=0): eff = (duty_sh*(grp_pwm_sh+1))>>8, 17-bit product, bits [15:8]; grp_pwm 255 gives exact duty, 0 gives 0.
  - mode 11, blink: eff = duty_sh when blink_on, else 0.
- Blink counter:
  - On each boundary, blink_cnt = (blink_cnt >= grp_freq_sh) ? 0 : blink_cnt+1, using the newly loaded grp_freq_sh.
  - Threshold thr = ((grp_freq_sh+1)*grp_pwm_sh)>>8, 9x8 product, 8-bit result.
  - blink_on = (blink_cnt < thr), registered. grp_pwm=0 gives always off.
- Channel output, registered (leds at edge n+1 reflects state at edge n):
  - mode 00 → 0; mode 01 → 1.
  - mode 1x → (pwm_cnt < eff). eff=0 gives always 0; eff=255 gives 255/256 high.
- ledout changes take effect on leds one cycle later, regardless of period position.
- Sleep:
  - leds, period_start, blink_on forced 0 on the next edge.
  - pre_cnt, pwm_cnt, blink_cnt held at 0; load_pending set.
  - On sleep deassert: counting resumes from 0; shadows reload on the first edge.
- Simultaneous sleep and boundary: sleep wins, no shadow load.
- Reset mid-period: immediate return to reset state, no partial-period output.

Optional Feature:
- Macro: LED_SHADOW_EN.
- Defined: duty, grp_pwm, grp_freq and dmblnk are sampled only at the boundary, as above; a mid-period write never produces a runt pulse.
- Undefined: shadow registers are transparent, so the effective value follows the inputs with 1-cycle register latency. blink_cnt still advances only at boundaries.

Test Plan:
1. PRESCALE=1, ch0 ledout=10, duty=0x40 → leds[0] high for exactly 64 of every 256 clk; period_start every 256 clk; other channels (ledout=00) stay 0.
2. ch1 ledout=01 → leds[1]=1 constant. ch2 ledout=10, duty=0x00 → always 0. ch3 ledout=10, duty=0xFF → 255 high per 256.
3. Dim: ch0 ledout=11, dmblnk=0, duty=0x80, grp_pwm=0x7F → 64 high cycles per period; grp_pwm=0xFF → 128.
4. Blink: dmblnk=1, grp_freq=3, grp_pwm=0x80, duty=0xFF → thr=2; blink_on high in periods 0,1, low in 2,3; pattern repeats every 4 periods.
5. LED_SHADOW_EN: change duty 0x40→0xC0 at pwm_cnt=0x10 → current period still 64 high, next period 192. Without the macro → 0xC0 applies 1 cycle after the change.
6. Assert sleep mid-period, then reset mid-period → leds/period_start/blink_on 0 next edge (reset: immediately). After release, first period_start 1 cycle later (PRESCALE=1) and duty reloaded.
